// File: rtl/axi_master_arbiter_pkg.sv
// Shared types and widths for the AXI master arbiter: channel FSM states,
// payload widths and a helper for index widths.
package axi_master_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = 4;
  localparam int WR_PAY_W = ADDR_W + DATA_W + STRB_W;
  localparam int RD_PAY_W = ADDR_W;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_master_arbiter_rr_arbiter.sv
// Round-robin selector: picks the first active request after the pointer,
// wrapping around, and reports it as both a one-hot grant and an index.
module round_robin_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    cand  = '0;
    idx   = '0;
    grant = '0;
    valid = |req;
    for (int i = N; i >= 1; i--) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (req[cand]) idx = cand;
    end
    if (valid) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one network master port among REQUESTER_NUMBER requesters; the write
// and read channels each run their own IDLE/ISSUE/WAIT arbitration FSM.
module axi_master_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter int REQUESTER_NUMBER = 2,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                              axi_ACLK,
  input  logic                              axi_ARESETN,
  input  logic [REQUESTER_NUMBER-1:0]       req_write_start_i,
  input  logic [REQUESTER_NUMBER-1:0][31:0] req_write_address_i,
  input  logic [REQUESTER_NUMBER-1:0][31:0] req_write_data_i,
  input  logic [REQUESTER_NUMBER-1:0][3:0]  req_write_strobe_i,
  output logic [REQUESTER_NUMBER-1:0]       req_write_grant_o,
  output logic [REQUESTER_NUMBER-1:0]       req_write_done_o,
  output logic [REQUESTER_NUMBER-1:0]       req_write_error_o,
  input  logic [REQUESTER_NUMBER-1:0]       req_read_start_i,
  input  logic [REQUESTER_NUMBER-1:0][31:0] req_read_address_i,
  input  logic [REQUESTER_NUMBER-1:0]       req_read_invalid_i,
  output logic [REQUESTER_NUMBER-1:0]       req_read_grant_o,
  output logic [REQUESTER_NUMBER-1:0]       req_read_done_o,
  output logic [REQUESTER_NUMBER-1:0]       req_read_error_o,
  output logic [31:0]                       req_read_data_o,
  output logic                              write_start_o,
  output logic [31:0]                       write_address_o,
  output logic [31:0]                       write_data_o,
  output logic [3:0]                        write_strobe_o,
  input  logic                              write_done_i,
  input  logic                              write_cts_i,
  output logic                              read_start_o,
  output logic                              read_invalid_o,
  output logic [31:0]                       read_address_o,
  input  logic [31:0]                       read_data_i,
  input  logic                              read_done_i,
  input  logic                              read_cts_i
);

  localparam int N     = REQUESTER_NUMBER;
  localparam int IDX_W = idx_width(N);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // Channel 0 is the write channel, channel 1 the read channel.
  for (genvar c = 0; c < 2; c++) begin : g_ch
    localparam int PW = (c == 0) ? WR_PAY_W : RD_PAY_W;

    logic [N-1:0]         req;
    logic                 cts;
    logic                 done_in;
    logic [N-1:0][PW-1:0] pay_in;

    if (c == 0) begin : g_io
      assign req     = req_write_start_i;
      assign cts     = write_cts_i;
      assign done_in = write_done_i;
      for (genvar k = 0; k < N; k++) begin : g_pay
        assign pay_in[k] = {req_write_address_i[k], req_write_data_i[k], req_write_strobe_i[k]};
      end
    end else begin : g_io
      assign req     = req_read_start_i;
      assign cts     = read_cts_i;
      assign done_in = read_done_i;
      assign pay_in  = req_read_address_i;
    end

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, ptr_q, arb_idx;
    logic [N-1:0]     owner_oh_q, arb_grant;
    logic             arb_valid;
    logic [PW-1:0]    pay_q;
    logic [CNT_W-1:0] cnt_q;
    logic             finish;
    logic             active;
    logic             start;
    logic [N-1:0]     grant, done, error;
    logic [PW-1:0]    pay_out;

    round_robin_arbiter #(
      .N     (N),
      .IDX_W (IDX_W)
    ) u_rr (
      .req   (req),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
    );

    always_comb begin
      state_d = state_q;
      start   = 1'b0;
      grant   = '0;
      done    = '0;
      error   = '0;
      finish  = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (arb_valid && cts) state_d = ISSUE;
        end
        ISSUE: begin
          start   = 1'b1;
          grant   = owner_oh_q;
          state_d = WAIT;
        end
        WAIT: begin
          // A real completion takes priority over a timeout in the same cycle.
          if (done_in) begin
            finish  = 1'b1;
            done    = owner_oh_q;
            state_d = IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            finish  = 1'b1;
            done    = owner_oh_q;
            error   = owner_oh_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
      if (!axi_ARESETN) begin
        state_q    <= IDLE;
        owner_q    <= '0;
        owner_oh_q <= '0;
        ptr_q      <= IDX_W'(N - 1);
        pay_q      <= '0;
        cnt_q      <= '0;
      end else begin
        state_q <= state_d;
        if (state_q == IDLE && state_d == ISSUE) begin
          owner_q    <= arb_idx;
          owner_oh_q <= arb_grant;
          pay_q      <= pay_in[arb_idx];
        end
        if (state_q == WAIT && !finish) cnt_q <= cnt_q + 1'b1;
        else                            cnt_q <= '0;
        if (finish) ptr_q <= owner_q;
      end
    end

    assign active  = (state_q != IDLE);
    assign pay_out = active ? pay_q : '0;
  end

  assign write_start_o     = g_ch[0].start;
  assign req_write_grant_o = g_ch[0].grant;
  assign req_write_done_o  = g_ch[0].done;
  assign req_write_error_o = g_ch[0].error;
  assign {write_address_o, write_data_o, write_strobe_o} = g_ch[0].pay_out;

  assign read_start_o      = g_ch[1].start;
  assign req_read_grant_o  = g_ch[1].grant;
  assign req_read_done_o   = g_ch[1].done;
  assign req_read_error_o  = g_ch[1].error;
  assign read_address_o    = g_ch[1].pay_out;
  assign read_invalid_o    = g_ch[1].active ? req_read_invalid_i[g_ch[1].owner_q] : 1'b0;
  assign req_read_data_o   = read_data_i;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Bench for axi_master_arbiter: table of write transactions, directed corner
// sequences, then randomized traffic against a transaction-level model.
module tb_axi_master_arbiter;

  localparam int N  = 2;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]       wr_start, rd_start, rd_inv;
  logic [N-1:0][31:0] wr_addr, wr_data, rd_addr;
  logic [N-1:0][3:0]  wr_strb;
  logic [N-1:0]       wr_grant, wr_done, wr_err, rd_grant, rd_done, rd_err;
  logic [31:0]        rd_data_o;
  logic               w_start, w_done_i, w_cts;
  logic [31:0]        w_addr, w_data;
  logic [3:0]         w_strb;
  logic               r_start, r_inv, r_done_i, r_cts;
  logic [31:0]        r_addr, r_data_i;

  axi_master_arbiter #(.REQUESTER_NUMBER(N), .TIMEOUT_CYCLES(TO)) dut (
    .axi_ACLK            (clk),
    .axi_ARESETN         (rst_n),
    .req_write_start_i   (wr_start),
    .req_write_address_i (wr_addr),
    .req_write_data_i    (wr_data),
    .req_write_strobe_i  (wr_strb),
    .req_write_grant_o   (wr_grant),
    .req_write_done_o    (wr_done),
    .req_write_error_o   (wr_err),
    .req_read_start_i    (rd_start),
    .req_read_address_i  (rd_addr),
    .req_read_invalid_i  (rd_inv),
    .req_read_grant_o    (rd_grant),
    .req_read_done_o     (rd_done),
    .req_read_error_o    (rd_err),
    .req_read_data_o     (rd_data_o),
    .write_start_o       (w_start),
    .write_address_o     (w_addr),
    .write_data_o        (w_data),
    .write_strobe_o      (w_strb),
    .write_done_i        (w_done_i),
    .write_cts_i         (w_cts),
    .read_start_o        (r_start),
    .read_invalid_o      (r_inv),
    .read_address_o      (r_addr),
    .read_data_i         (r_data_i),
    .read_done_i         (r_done_i),
    .read_cts_i          (r_cts)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] addr0, data0, addr1, data1;
    logic [3:0]  strb0, strb1;
    logic [1:0]  exp_grant;
    logic [31:0] exp_addr, exp_data;
    logic [3:0]  exp_strb;
  } wr_vec_t;

  wr_vec_t tbl [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_expired(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [127:0] wr_act();
    return 128'({w_start, wr_grant, wr_done, wr_err, w_addr, w_data, w_strb});
  endfunction

  function automatic logic [127:0] rd_act();
    return 128'({r_start, r_inv, rd_grant, rd_done, rd_err, r_addr, rd_data_o});
  endfunction

  task automatic clear_inputs();
    wr_start = '0; rd_start = '0; rd_inv = '0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; wr_strb = '0;
    w_done_i = 1'b0; w_cts = 1'b0; r_done_i = 1'b0; r_cts = 1'b0; r_data_i = '0;
  endtask

  // Transaction-level reference: age -1 = no transaction, 0 = issue cycle,
  // age k >= 1 = (k-1)th cycle spent waiting for the network.
  int          m_age [2];
  int          m_own [2];
  int          m_last [2];
  logic [31:0] m_addr [2], m_data [2];
  logic [3:0]  m_strb [2];

  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    for (int i = 1; i <= N; i++)
      for (int k = 0; k < N; k++)
        if (k == (last + i) % N && req[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_age[c] = -1; m_own[c] = 0; m_last[c] = N - 1;
      m_addr[c] = '0; m_data[c] = '0; m_strb[c] = '0;
    end
  endtask

  task automatic model_check_and_step();
    logic [N-1:0] req [2];
    logic         cts [2];
    logic         dn [2];
    logic [N-1:0] g, d, e, oh;
    logic         s, inv, fin;
    logic [31:0]  a, dt;
    logic [3:0]   sb;
    int           o;
    req[0] = wr_start; req[1] = rd_start;
    cts[0] = w_cts;    cts[1] = r_cts;
    dn[0]  = w_done_i; dn[1]  = r_done_i;
    for (int c = 0; c < 2; c++) begin
      g = '0; d = '0; e = '0; s = 1'b0; inv = 1'b0; fin = 1'b0;
      a = '0; dt = '0; sb = '0;
      oh = '0; oh[0] = 1'b1; oh = oh << m_own[c];
      if (m_age[c] >= 0) begin
        a = m_addr[c]; dt = m_data[c]; sb = m_strb[c];
        for (int k = 0; k < N; k++) if (k == m_own[c]) inv = rd_inv[k];
      end
      if (m_age[c] == 0) begin
        s = 1'b1; g = oh;
      end else if (m_age[c] >= 1 && (dn[c] || (m_age[c] - 1) == TO)) begin
        fin = 1'b1; d = oh;
        if (!dn[c]) e = oh;
      end
      if (c == 0) chk("rand write", wr_act(), 128'({s, g, d, e, a, dt, sb}));
      else        chk("rand read", rd_act(), 128'({s, inv, g, d, e, a, r_data_i}));
      if (m_age[c] < 0) begin
        if (cts[c] && req[c] != '0) begin
          o = rr_pick(m_last[c], req[c]);
          m_own[c] = o;
          m_age[c] = 0;
          for (int k = 0; k < N; k++) begin
            if (k == o) begin
              if (c == 0) begin
                m_addr[c] = wr_addr[k]; m_data[c] = wr_data[k]; m_strb[c] = wr_strb[k];
              end else begin
                m_addr[c] = rd_addr[k]; m_data[c] = '0; m_strb[c] = '0;
              end
            end
          end
        end
      end else if (fin) begin
        m_last[c] = m_own[c];
        m_age[c]  = -1;
      end else begin
        m_age[c]++;
      end
    end
  endtask

  initial begin
    bit found;
    int w_hit;
    logic [1:0] exp_g;

    tbl[0] = '{2'b10, 32'h2000, 32'h0BAD0000, 32'h1000, 32'hDEADBEEF, 4'h3, 4'hF, 2'b10, 32'h1000, 32'hDEADBEEF, 4'hF};
    tbl[1] = '{2'b11, 32'h2004, 32'h11111111, 32'h1004, 32'h22222222, 4'h1, 4'h2, 2'b01, 32'h2004, 32'h11111111, 4'h1};
    tbl[2] = '{2'b11, 32'h2008, 32'h33333333, 32'h1008, 32'h44444444, 4'h4, 4'h8, 2'b10, 32'h1008, 32'h44444444, 4'h8};
    tbl[3] = '{2'b01, 32'h200C, 32'h55555555, 32'h100C, 32'h66666666, 4'hC, 4'h3, 2'b01, 32'h200C, 32'h55555555, 4'hC};
    tbl[4] = '{2'b01, 32'h2010, 32'h77777777, 32'h1010, 32'h88888888, 4'h5, 4'hA, 2'b01, 32'h2010, 32'h77777777, 4'h5};
    tbl[5] = '{2'b11, 32'h2014, 32'h99999999, 32'h1014, 32'hAAAAAAAA, 4'h6, 4'h9, 2'b10, 32'h1014, 32'hAAAAAAAA, 4'h9};

    clear_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    #1;
    chk("reset write outputs", wr_act(), '0);
    chk("reset read outputs", rd_act(), '0);
    rst_n = 1'b1;
    w_cts = 1'b1;
    r_cts = 1'b1;
    tick();

    // Write transactions from the table, back to back.
    for (int i = 0; i < 6; i++) begin
      wr_start = tbl[i].req;
      wr_addr[0] = tbl[i].addr0; wr_data[0] = tbl[i].data0; wr_strb[0] = tbl[i].strb0;
      wr_addr[1] = tbl[i].addr1; wr_data[1] = tbl[i].data1; wr_strb[1] = tbl[i].strb1;
      #1 chk("table idle", wr_act(), '0);
      tick();
      #1 chk("table issue", wr_act(),
             128'({1'b1, tbl[i].exp_grant, 2'b00, 2'b00, tbl[i].exp_addr, tbl[i].exp_data, tbl[i].exp_strb}));
      wr_start = '0;
      wr_addr = '1; wr_data = '1; wr_strb = '1;
      tick();
      #1 chk("table wait", wr_act(),
             128'({1'b0, 2'b00, 2'b00, 2'b00, tbl[i].exp_addr, tbl[i].exp_data, tbl[i].exp_strb}));
      w_done_i = 1'b1;
      #1 chk("table done", wr_act(),
             128'({1'b0, 2'b00, tbl[i].exp_grant, 2'b00, tbl[i].exp_addr, tbl[i].exp_data, tbl[i].exp_strb}));
      tick();
      w_done_i = 1'b0;
      #1 chk("table back idle", wr_act(), '0);
    end

    // Clear-to-send held low: no issue; stray done_i ignored.
    w_cts = 1'b0;
    w_done_i = 1'b1;
    wr_start = 2'b01;
    wr_addr[0] = 32'h3000; wr_data[0] = 32'hCAFEF00D; wr_strb[0] = 4'hA;
    for (int i = 0; i < 10; i++) begin
      #1 chk("cts low idle", 128'({w_start, wr_grant, wr_done, wr_err}), '0);
      tick();
    end
    w_cts = 1'b1;
    w_done_i = 1'b0;
    #1 chk("cts rise same cycle", 128'(w_start), '0);
    tick();
    #1 chk("cts rise issue", wr_act(), 128'({1'b1, 2'b01, 2'b00, 2'b00, 32'h3000, 32'hCAFEF00D, 4'hA}));
    wr_start = '0;
    tick();
    w_done_i = 1'b1;
    #1 chk("cts done", 128'(wr_done), 128'(2'b01));
    tick();
    w_done_i = 1'b0;

    // Two readers held continuously alternate.
    rd_start = 2'b11;
    rd_addr[0] = 32'hA000; rd_addr[1] = 32'hB000;
    rd_inv = 2'b10;
    for (int t = 0; t < 4; t++) begin
      found = 1'b0;
      for (int w = 0; w < 6 && !found; w++) begin
        tick();
        #1 if (r_start) found = 1'b1;
      end
      if (!found) begin
        bound_expired("rr read start");
      end else begin
        exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
        chk("rr grant", 128'(rd_grant), 128'(exp_g));
        chk("rr address", 128'(r_addr), (t % 2 == 0) ? 128'(32'hA000) : 128'(32'hB000));
        chk("rr invalid", 128'(r_inv), 128'(t % 2));
        tick();
        r_done_i = 1'b1;
        r_data_i = 32'h0F0F0000 + 32'(t);
        #1 chk("rr done", 128'({rd_done, rd_data_o}), 128'({exp_g, 32'h0F0F0000 + 32'(t)}));
        tick();
        r_done_i = 1'b0;
      end
    end
    rd_start = '0;
    rd_inv = '0;
    r_data_i = '0;

    // Read with no response times out after TO waiting cycles.
    tick();
    rd_start = 2'b01;
    rd_addr[0] = 32'hA100;
    found = 1'b0;
    for (int w = 0; w < 6 && !found; w++) begin
      tick();
      #1 if (r_start) found = 1'b1;
    end
    rd_start = '0;
    if (!found) begin
      bound_expired("timeout read start");
    end else begin
      found = 1'b0;
      w_hit = -1;
      for (int w = 0; w < 300 && !found; w++) begin
        tick();
        #1 if ((rd_err | rd_done) != '0) begin
          found = 1'b1;
          w_hit = w;
        end
      end
      if (!found) begin
        bound_expired("timeout error pulse");
      end else begin
        chk("timeout wait cycles", 128'(w_hit), 128'(TO));
        chk("timeout flags", 128'({rd_err, rd_done}), 128'({2'b01, 2'b01}));
        tick();
        #1 chk("timeout back idle", rd_act(), '0);
      end
    end

    // Concurrent write (req 0) and read (req 1).
    wr_start = 2'b01;
    wr_addr[0] = 32'h4000; wr_data[0] = 32'h0A0B0C0D; wr_strb[0] = 4'hF;
    rd_start = 2'b10;
    rd_addr[1] = 32'hC000;
    r_data_i = 32'h12345678;
    tick();
    #1 chk("conc write issue", 128'({w_start, wr_grant}), 128'({1'b1, 2'b01}));
    chk("conc read issue", 128'({r_start, rd_grant, r_addr}), 128'({1'b1, 2'b10, 32'hC000}));
    wr_start = '0;
    rd_start = '0;
    tick();
    w_done_i = 1'b1;
    #1 chk("conc write done", 128'({wr_done, wr_err}), 128'({2'b01, 2'b00}));
    chk("conc read still waiting", 128'({rd_done, r_addr}), 128'({2'b00, 32'hC000}));
    tick();
    w_done_i = 1'b0;
    r_done_i = 1'b1;
    #1 chk("conc read done", 128'({rd_done, rd_err, rd_data_o}), 128'({2'b10, 2'b00, 32'h12345678}));
    chk("conc write idle", wr_act(), '0);
    tick();
    r_done_i = 1'b0;
    r_data_i = '0;

    // Reset while a write waits: outputs drop at once, pointer restarts at 0.
    wr_start = 2'b01;
    wr_addr[0] = 32'h5000; wr_data[0] = 32'h55AA55AA; wr_strb[0] = 4'h1;
    tick();
    wr_start = '0;
    tick();
    #1 chk("pre-reset wait", wr_act(), 128'({1'b0, 6'b0, 32'h5000, 32'h55AA55AA, 4'h1}));
    w_done_i = 1'b1;
    rst_n = 1'b0;
    #1 chk("async reset write", wr_act(), '0);
    chk("async reset read", rd_act(), '0);
    tick();
    #1 chk("reset holds", 128'({wr_done, wr_err}), '0);
    tick();
    rst_n = 1'b1;
    w_done_i = 1'b0;
    wr_start = 2'b11;
    wr_addr[1] = 32'h6000;
    tick();
    #1 chk("post-reset winner", 128'({w_start, wr_grant, w_addr}), 128'({1'b1, 2'b01, 32'h5000}));
    wr_start = '0;
    tick();
    w_done_i = 1'b1;
    #1 chk("post-reset done", 128'(wr_done), 128'(2'b01));
    tick();
    w_done_i = 1'b0;

    // Randomized traffic against the reference model.
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      wr_start = N'($urandom_range(0, (1 << N) - 1));
      rd_start = N'($urandom_range(0, (1 << N) - 1));
      rd_inv   = N'($urandom_range(0, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        wr_addr[k] = $urandom; wr_data[k] = $urandom;
        wr_strb[k] = 4'($urandom_range(0, 15));
        rd_addr[k] = $urandom;
      end
      w_cts    = ($urandom_range(0, 3) != 0);
      r_cts    = ($urandom_range(0, 3) != 0);
      w_done_i = ($urandom_range(0, 3) == 0);
      r_done_i = ($urandom_range(0, 3) == 0);
      r_data_i = $urandom;
      #1 model_check_and_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
